// File: rtl/ftq_param.sv
// rtl/ftq_param.sv - fetch target queue between BPU and icache/backend
// Wrap-bit pointers, fetch bypass/replay, N-way read and writeback ports, gated BPU update drain.
module ftq_param #(
   parameter int DEPTH    = 16,
   parameter int XLEN     = 64,
   parameter int RD_PORTS = 2,
   parameter int WB_PORTS = 2,
   parameter int PW       = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_enq_vld,
   output logic                     o_enq_rdy,
   input  logic [XLEN-1:0]          i_enq_start,
   input  logic [XLEN-1:0]          i_enq_end,
   input  logic                     i_enq_taken,
   input  logic [XLEN-1:0]          i_enq_target,
   output logic [PW-1:0]            o_enq_idx,
   output logic                     o_fetch_vld,
   input  logic                     i_fetch_rdy,
   output logic [PW-1:0]            o_fetch_idx,
   output logic [XLEN-1:0]          o_fetch_start,
   output logic [XLEN-1:0]          o_fetch_size,
   input  logic                     i_replay_vld,
   input  logic [PW-1:0]            i_replay_idx,
   input  logic [RD_PORTS*PW-1:0]   i_rd_idx,
   output logic [RD_PORTS*XLEN-1:0] o_rd_start,
   output logic [RD_PORTS*XLEN-1:0] o_rd_next,
   input  logic [WB_PORTS-1:0]      i_wb_vld,
   input  logic [WB_PORTS*PW-1:0]   i_wb_idx,
   input  logic [WB_PORTS-1:0]      i_wb_mispred,
   input  logic [WB_PORTS-1:0]      i_wb_taken,
   input  logic [WB_PORTS*XLEN-1:0] i_wb_target,
   input  logic                     i_commit_vld,
   input  logic [PW-1:0]            i_commit_idx,
   input  logic                     i_squash_vld,
   input  logic [PW-1:0]            i_squash_idx,
   output logic                     o_upd_vld,
   input  logic                     i_upd_rdy,
   output logic [XLEN-1:0]          o_upd_start,
   output logic [XLEN-1:0]          o_upd_target,
   output logic                     o_upd_taken,
   output logic                     o_upd_mispred,
   output logic [PW-1:0]            o_count
);
   localparam int SW = PW - 1;

   logic [PW-1:0]   enq_ptr, fetch_ptr, deq_ptr, thre;
   logic [XLEN-1:0] start_q [DEPTH];
   logic [XLEN-1:0] end_q   [DEPTH];
   logic [XLEN-1:0] next_q  [DEPTH];
   logic [XLEN-1:0] target_q[DEPTH];
   logic [DEPTH-1:0] taken_q, mispred_q, valid_q, sq_keep;
   logic [RD_PORTS*XLEN-1:0] rd_start_q, rd_next_q;

   logic [SW-1:0] enq_slot, fetch_slot, deq_slot;
   logic          full, enq_fire, fetch_pend, bypass, fetch_fire;
   logic          head_pend, head_mis, deq_fire;
   logic [PW-1:0] sq_enq, sq_cnt;
   logic          unused_bits;

   assign enq_slot   = enq_ptr[SW-1:0];
   assign fetch_slot = fetch_ptr[SW-1:0];
   assign deq_slot   = deq_ptr[SW-1:0];

   assign full      = (enq_slot == deq_slot) && (enq_ptr[PW-1] != deq_ptr[PW-1]);
   assign o_enq_rdy = !full;
   assign enq_fire  = i_enq_vld && o_enq_rdy && !i_squash_vld;
   assign o_enq_idx = enq_ptr;
   assign o_count   = enq_ptr - deq_ptr;

   // An empty fetch window forwards the incoming prediction straight to the icache.
   assign fetch_pend    = (fetch_ptr != enq_ptr);
   assign bypass        = !fetch_pend && enq_fire;
   assign o_fetch_vld   = fetch_pend || bypass;
   assign o_fetch_idx   = fetch_ptr;
   assign o_fetch_start = bypass ? i_enq_start : start_q[fetch_slot];
   assign o_fetch_size  = bypass ? (i_enq_end - i_enq_start)
                                 : (end_q[fetch_slot] - start_q[fetch_slot]);
   assign fetch_fire    = o_fetch_vld && i_fetch_rdy && !i_squash_vld;

   assign head_pend     = (deq_ptr != thre) && valid_q[deq_slot];
   assign head_mis      = mispred_q[deq_slot];
   assign o_upd_vld     = head_pend && head_mis && !i_squash_vld;
   assign deq_fire      = head_pend && !i_squash_vld && (!head_mis || i_upd_rdy);
   assign o_upd_start   = start_q[deq_slot];
   assign o_upd_target  = target_q[deq_slot];
   assign o_upd_taken   = taken_q[deq_slot];
   assign o_upd_mispred = head_mis;

   assign sq_enq = i_squash_idx + PW'(1);
   assign sq_cnt = sq_enq - deq_ptr;

   // Slots whose distance from the head falls inside the surviving window keep their valid bit.
   for (genvar k = 0; k < DEPTH; k++) begin : g_keep
      logic [SW-1:0] off;
      assign off        = SW'(k) - deq_slot;
      assign sq_keep[k] = ({1'b0, off} < sq_cnt);
   end

   assign o_rd_start  = rd_start_q;
   assign o_rd_next   = rd_next_q;
   assign unused_bits = ^{i_rd_idx, i_wb_idx};

   always_ff @(posedge clk) begin
      if (!rst) begin
         enq_ptr    <= '0;
         fetch_ptr  <= '0;
         deq_ptr    <= '0;
         thre       <= '0;
         valid_q    <= '0;
         mispred_q  <= '0;
         rd_start_q <= '0;
         rd_next_q  <= '0;
      end else begin
         if (i_commit_vld)
            thre <= i_commit_idx;
         // Ascending port order lets the highest port win; the enqueue below overrides both.
         for (int p = 0; p < WB_PORTS; p++) begin
            if (i_wb_vld[p]) begin
               mispred_q[i_wb_idx[p*PW +: SW]] <= i_wb_mispred[p];
               taken_q[i_wb_idx[p*PW +: SW]]   <= i_wb_taken[p];
               target_q[i_wb_idx[p*PW +: SW]]  <= i_wb_target[p*XLEN +: XLEN];
            end
         end
         if (i_squash_vld) begin
            enq_ptr   <= sq_enq;
            fetch_ptr <= sq_enq;
            valid_q   <= valid_q & sq_keep;
         end else begin
            if (enq_fire) begin
               start_q[enq_slot]   <= i_enq_start;
               end_q[enq_slot]     <= i_enq_end;
               next_q[enq_slot]    <= i_enq_taken ? i_enq_target : i_enq_end;
               target_q[enq_slot]  <= i_enq_target;
               taken_q[enq_slot]   <= i_enq_taken;
               mispred_q[enq_slot] <= 1'b0;
               valid_q[enq_slot]   <= 1'b1;
               enq_ptr             <= enq_ptr + PW'(1);
            end
            if (i_replay_vld)
               fetch_ptr <= i_replay_idx;
            else if (fetch_fire)
               fetch_ptr <= fetch_ptr + PW'(1);
            if (deq_fire) begin
               valid_q[deq_slot] <= 1'b0;
               deq_ptr           <= deq_ptr + PW'(1);
            end
         end
         for (int p = 0; p < RD_PORTS; p++) begin
            rd_start_q[p*XLEN +: XLEN] <= start_q[i_rd_idx[p*PW +: SW]];
            rd_next_q[p*XLEN +: XLEN]  <= next_q[i_rd_idx[p*PW +: SW]];
         end
      end
   end
endmodule

// File: tb/tb_ftq_param.sv
// tb/tb_ftq_param.sv - scoreboard bench for ftq_param
// Directed stimulus; fetch and BPU-update expectations are queued and checked by a monitor.
module tb_ftq_param;
   localparam int DEPTH = 16;
   localparam int XLEN  = 64;
   localparam int PW    = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_enq_vld, i_enq_taken, i_fetch_rdy, i_replay_vld;
   logic [XLEN-1:0]   i_enq_start, i_enq_end, i_enq_target;
   logic [PW-1:0]     i_replay_idx, i_commit_idx, i_squash_idx;
   logic [2*PW-1:0]   i_rd_idx, i_wb_idx;
   logic [1:0]        i_wb_vld, i_wb_mispred, i_wb_taken;
   logic [2*XLEN-1:0] i_wb_target;
   logic              i_commit_vld, i_squash_vld, i_upd_rdy;
   logic              o_enq_rdy, o_fetch_vld, o_upd_vld, o_upd_taken, o_upd_mispred;
   logic [PW-1:0]     o_enq_idx, o_fetch_idx, o_count;
   logic [XLEN-1:0]   o_fetch_start, o_fetch_size, o_upd_start, o_upd_target;
   logic [2*XLEN-1:0] o_rd_start, o_rd_next;

   typedef struct {
      logic [PW-1:0]   idx;
      logic [XLEN-1:0] start;
      logic [XLEN-1:0] size;
   } fexp_t;
   typedef struct {
      logic [XLEN-1:0] start;
      logic [XLEN-1:0] target;
      logic            taken;
      logic            mispred;
   } uexp_t;

   fexp_t fq[$];
   uexp_t uq[$];
   int checks = 0;
   int failures = 0;
   logic seen;

   ftq_param #(.DEPTH(DEPTH), .XLEN(XLEN), .RD_PORTS(2), .WB_PORTS(2), .PW(PW)) dut (
      .clk(clk), .rst(rst),
      .i_enq_vld(i_enq_vld), .o_enq_rdy(o_enq_rdy), .i_enq_start(i_enq_start),
      .i_enq_end(i_enq_end), .i_enq_taken(i_enq_taken), .i_enq_target(i_enq_target),
      .o_enq_idx(o_enq_idx), .o_fetch_vld(o_fetch_vld), .i_fetch_rdy(i_fetch_rdy),
      .o_fetch_idx(o_fetch_idx), .o_fetch_start(o_fetch_start), .o_fetch_size(o_fetch_size),
      .i_replay_vld(i_replay_vld), .i_replay_idx(i_replay_idx),
      .i_rd_idx(i_rd_idx), .o_rd_start(o_rd_start), .o_rd_next(o_rd_next),
      .i_wb_vld(i_wb_vld), .i_wb_idx(i_wb_idx), .i_wb_mispred(i_wb_mispred),
      .i_wb_taken(i_wb_taken), .i_wb_target(i_wb_target),
      .i_commit_vld(i_commit_vld), .i_commit_idx(i_commit_idx),
      .i_squash_vld(i_squash_vld), .i_squash_idx(i_squash_idx),
      .o_upd_vld(o_upd_vld), .i_upd_rdy(i_upd_rdy), .o_upd_start(o_upd_start),
      .o_upd_target(o_upd_target), .o_upd_taken(o_upd_taken),
      .o_upd_mispred(o_upd_mispred), .o_count(o_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit check);
      rst = 1'b0;
      i_enq_vld = 0; i_enq_taken = 0; i_enq_start = '0; i_enq_end = '0; i_enq_target = '0;
      i_fetch_rdy = 0; i_replay_vld = 0; i_replay_idx = '0; i_rd_idx = '0;
      i_wb_vld = '0; i_wb_idx = '0; i_wb_mispred = '0; i_wb_taken = '0; i_wb_target = '0;
      i_commit_vld = 0; i_commit_idx = '0; i_squash_vld = 0; i_squash_idx = '0; i_upd_rdy = 0;
      tick();
      tick();
      if (check) begin
         @(negedge clk);
         chk("rst_enq_rdy", o_enq_rdy, 1);
         chk("rst_fetch_vld", o_fetch_vld, 0);
         chk("rst_upd_vld", o_upd_vld, 0);
         chk("rst_count", o_count, 0);
         chk("rst_rd_start", o_rd_start, 0);
         tick();
      end
      rst = 1'b1;
   endtask

   task automatic enq(input logic [63:0] s, input logic [63:0] e);
      i_enq_vld = 1; i_enq_start = s; i_enq_end = e;
      tick();
      i_enq_vld = 0;
   endtask

   // Scoreboard monitor: pops an expectation whenever a fetch or update handshake is presented.
   always @(negedge clk) begin
      fexp_t fe;
      uexp_t ue;
      if (rst && o_fetch_vld && i_fetch_rdy) begin
         if (fq.size() == 0) chk("fetch_unexpected", {59'd0, o_fetch_idx}, 64'hFFFF);
         else begin
            fe = fq.pop_front();
            chk("fetch_idx", {59'd0, o_fetch_idx}, {59'd0, fe.idx});
            chk("fetch_start", o_fetch_start, fe.start);
            chk("fetch_size", o_fetch_size, fe.size);
         end
      end
      if (rst && o_upd_vld && i_upd_rdy) begin
         if (uq.size() == 0) chk("upd_unexpected", o_upd_start, 64'hFFFF);
         else begin
            ue = uq.pop_front();
            chk("upd_start", o_upd_start, ue.start);
            chk("upd_target", o_upd_target, ue.target);
            chk("upd_taken", o_upd_taken, ue.taken);
            chk("upd_mispred", o_upd_mispred, ue.mispred);
         end
      end
   end

   initial begin
      do_reset(1);

      // Fill to full with fetch stalled
      for (int i = 0; i < 16; i++) enq(64'h1000 + 64'h20 * i, 64'h1020 + 64'h20 * i);
      @(negedge clk);
      chk("full_count", o_count, 16);
      chk("full_enq_rdy", o_enq_rdy, 0);
      chk("full_fetch_vld", o_fetch_vld, 1);
      chk("full_fetch_idx", o_fetch_idx, 0);
      chk("full_fetch_size", o_fetch_size, 64'h20);
      chk("full_fetch_start", o_fetch_start, 64'h1000);
      tick();
      enq(64'hDEAD, 64'hDEBD);
      @(negedge clk);
      chk("full_17th_count", o_count, 16);
      chk("full_17th_enq_idx", o_enq_idx, 16);
      tick();

      // Bypass
      do_reset(0);
      fq.push_back('{idx: 5'd0, start: 64'h8000, size: 64'h10});
      i_fetch_rdy = 1;
      enq(64'h8000, 64'h8010);
      i_fetch_rdy = 0;
      @(negedge clk);
      chk("bypass_fetch_ptr", o_fetch_idx, 1);
      chk("bypass_next_vld", o_fetch_vld, 0);
      tick();

      // Wrap-around with continuous commit/drain
      do_reset(0);
      for (int i = 0; i < 20; i++) begin
         i_commit_vld = 1;
         i_commit_idx = o_enq_idx;
         i_enq_vld = 1; i_enq_start = 64'h2000 + 64'h40 * i; i_enq_end = 64'h2040 + 64'h40 * i;
         @(negedge clk);
         chk("wrap_count_le16", (o_count <= 16), 1);
         tick();
      end
      i_enq_vld = 0; i_commit_vld = 0;
      i_rd_idx = {5'h13, 5'h12};
      @(negedge clk);
      chk("wrap_enq_idx", o_enq_idx, 5'h14);
      tick();
      @(negedge clk);
      chk("wrap_rd0_start", o_rd_start[63:0], 64'h2480);
      chk("wrap_rd0_next", o_rd_next[63:0], 64'h24C0);
      chk("wrap_rd1_start", o_rd_start[127:64], 64'h24C0);
      tick();

      // Mispredict drain with back-pressure
      do_reset(0);
      for (int i = 0; i < 6; i++) enq(64'h3000 + 64'h10 * i, 64'h3010 + 64'h10 * i);
      i_wb_vld = 2'b10; i_wb_idx = {5'd3, 5'd0}; i_wb_mispred = 2'b10; i_wb_taken = 2'b10;
      i_wb_target = {64'h4000, 64'h0};
      tick();
      i_wb_vld = 0;
      uq.push_back('{start: 64'h3030, target: 64'h4000, taken: 1'b1, mispred: 1'b1});
      i_commit_vld = 1; i_commit_idx = 5;
      tick();
      i_commit_vld = 0;
      seen = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (o_upd_vld) begin
            seen = 1;
            break;
         end
      end
      chk("mis_upd_seen", seen, 1);
      for (int k = 0; k < 3; k++) begin
         chk("mis_hold_vld", o_upd_vld, 1);
         chk("mis_hold_target", o_upd_target, 64'h4000);
         chk("mis_hold_count", o_count, 3);
         tick();
         if (k == 2) i_upd_rdy = 1;
         @(negedge clk);
      end
      tick();
      i_upd_rdy = 0;
      @(negedge clk);
      chk("mis_after_count", o_count, 2);
      tick();

      // Squash drops the simultaneous enqueue
      do_reset(0);
      for (int i = 0; i < 10; i++) enq(64'h5000 + 64'h10 * i, 64'h5010 + 64'h10 * i);
      i_squash_vld = 1; i_squash_idx = 4;
      enq(64'h9999, 64'h99A9);
      i_squash_vld = 0;
      @(negedge clk);
      chk("sq_enq_idx", o_enq_idx, 5);
      chk("sq_fetch_idx", o_fetch_idx, 5);
      chk("sq_count", o_count, 5);
      chk("sq_fetch_vld", o_fetch_vld, 0);
      tick();
      enq(64'h6000, 64'h6010);
      i_rd_idx = {5'd0, 5'd5};
      tick();
      @(negedge clk);
      chk("sq_rd_slot5", o_rd_start[63:0], 64'h6000);
      tick();

      // Writeback collision, replay vs handshake
      do_reset(0);
      for (int i = 0; i < 4; i++) enq(64'h7000 + 64'h10 * i, 64'h7010 + 64'h10 * i);
      i_wb_vld = 2'b11; i_wb_idx = {5'd2, 5'd2}; i_wb_mispred = 2'b11; i_wb_taken = 2'b11;
      i_wb_target = {64'hB, 64'hA};
      tick();
      i_wb_vld = 0;
      for (int i = 0; i < 3; i++)
         fq.push_back('{idx: 5'(i), start: 64'h7000 + 64'h10 * i, size: 64'h10});
      i_fetch_rdy = 1;
      tick();
      tick();
      i_replay_vld = 1; i_replay_idx = 1;
      tick();
      i_replay_vld = 0; i_fetch_rdy = 0;
      @(negedge clk);
      chk("replay_fetch_idx", o_fetch_idx, 1);
      tick();
      uq.push_back('{start: 64'h7020, target: 64'hB, taken: 1'b1, mispred: 1'b1});
      i_commit_vld = 1; i_commit_idx = 3;
      tick();
      i_commit_vld = 0;
      i_upd_rdy = 1;
      seen = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (o_upd_vld) begin
            seen = 1;
            break;
         end
      end
      chk("wb_upd_seen", seen, 1);
      tick();
      i_upd_rdy = 0;

      chk("fetch_queue_drained", fq.size(), 0);
      chk("upd_queue_drained", uq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
